// File: rtl/braille_cell_encoder.sv
// Braille trainer input stage: synchronizes six dot switches and a Submit button,
// debounces Submit and emits one 4-bit letter code per accepted press.
module braille_cell_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] Dots_In,
  input  logic       Submit_Btn,
  input  logic       Enable,
  output logic [3:0] Code_Out,
  output logic       Code_Valid,
  output logic       Code_Err,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DEBOUNCE = 2'b01,
    CAPTURE  = 2'b10,
    RELEASE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {err, code}; anything not an exact six-dot match maps to the error code.
  function automatic logic [4:0] encode_cell(input logic [5:0] dots);
    case (dots)
      6'b000001: encode_cell = {1'b0, 4'b0000}; // A
      6'b000011: encode_cell = {1'b0, 4'b0001}; // B
      6'b001001: encode_cell = {1'b0, 4'b0010}; // C
      6'b011001: encode_cell = {1'b0, 4'b0011}; // D
      6'b010001: encode_cell = {1'b0, 4'b0100}; // E
      6'b001011: encode_cell = {1'b0, 4'b0101}; // F
      6'b011011: encode_cell = {1'b0, 4'b0110}; // G
      6'b010011: encode_cell = {1'b0, 4'b0111}; // H
      6'b001010: encode_cell = {1'b0, 4'b1000}; // I
      6'b011010: encode_cell = {1'b0, 4'b1001}; // J
      6'b000111: encode_cell = {1'b0, 4'b1010}; // L
      6'b010101: encode_cell = {1'b0, 4'b1011}; // O
      6'b001111: encode_cell = {1'b0, 4'b1100}; // P
      6'b001110: encode_cell = {1'b0, 4'b1101}; // S
      6'b100101: encode_cell = {1'b0, 4'b1110}; // U
      default:   encode_cell = {1'b1, 4'b1111};
    endcase
  endfunction

  // Saturating increment so the counter can never wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_LAST) begin
      cnt_inc = cnt;
    end else begin
      cnt_inc = cnt + CNT_ONE;
    end
  endfunction

  logic [5:0]       dots_meta_r;
  logic [5:0]       dots_sync_r;
  logic             sub_meta_r;
  logic             sub_sync_r;
  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [3:0]       code_r;
  logic [3:0]       code_next_s;
  logic             err_r;
  logic             err_next_s;
  logic             valid_r;
  logic             valid_next_s;
  logic             busy_r;
  logic             busy_next_s;
  logic [4:0]       cell_s;

  // Two-flop synchronizers for the asynchronous switch and button inputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dots_meta_r <= 6'b000000;
      dots_sync_r <= 6'b000000;
      sub_meta_r  <= 1'b0;
      sub_sync_r  <= 1'b0;
    end else begin
      dots_meta_r <= Dots_In;
      dots_sync_r <= dots_meta_r;
      sub_meta_r  <= Submit_Btn;
      sub_sync_r  <= sub_meta_r;
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter logic; dropping Enable forces IDLE from any state.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    if (!Enable) begin
      next_state_s = IDLE;
      cnt_next_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_next_s = CNT_ZERO;
          if (sub_sync_r) begin
            next_state_s = DEBOUNCE;
          end else begin
            next_state_s = IDLE;
          end
        end
        DEBOUNCE: begin
          if (!sub_sync_r) begin
            next_state_s = IDLE;
            cnt_next_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            next_state_s = CAPTURE;
            cnt_next_s   = CNT_ZERO;
          end else begin
            next_state_s = DEBOUNCE;
            cnt_next_s   = cnt_inc(cnt_r);
          end
        end
        CAPTURE: begin
          next_state_s = RELEASE;
          cnt_next_s   = CNT_ZERO;
        end
        RELEASE: begin
          if (sub_sync_r) begin
            next_state_s = RELEASE;
            cnt_next_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            next_state_s = IDLE;
            cnt_next_s   = CNT_ZERO;
          end else begin
            next_state_s = RELEASE;
            cnt_next_s   = cnt_inc(cnt_r);
          end
        end
        default: begin
          next_state_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode: outputs are loaded on the edge that enters CAPTURE so the
  // valid pulse coincides with the CAPTURE cycle.
  always_comb begin
    cell_s       = encode_cell(dots_sync_r);
    code_next_s  = code_r;
    err_next_s   = err_r;
    valid_next_s = 1'b0;
    busy_next_s  = (next_state_s != IDLE);
    if (next_state_s == CAPTURE) begin
      code_next_s  = cell_s[3:0];
      err_next_s   = cell_s[4];
      valid_next_s = 1'b1;
    end else begin
      code_next_s  = code_r;
      err_next_s   = err_r;
      valid_next_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      code_r  <= 4'b1111;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      code_r  <= code_next_s;
      err_r   <= err_next_s;
      valid_r <= valid_next_s;
      busy_r  <= busy_next_s;
    end
  end

  assign Code_Out   = code_r;
  assign Code_Err   = err_r;
  assign Code_Valid = valid_r;
  assign Busy       = busy_r;

endmodule

// File: tb/tb_braille_cell_encoder.sv
// Directed bench for braille_cell_encoder with DEBOUNCE_CYCLES=4: table of cells
// plus hand-written glitch, bounce, enable and reset sequences.
module tb_braille_cell_encoder;

  logic       Clk;
  logic       Rst;
  logic [5:0] Dots_In;
  logic       Submit_Btn;
  logic       Enable;
  logic [3:0] Code_Out;
  logic       Code_Valid;
  logic       Code_Err;
  logic       Busy;

  braille_cell_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Dots_In    (Dots_In),
    .Submit_Btn (Submit_Btn),
    .Enable     (Enable),
    .Code_Out   (Code_Out),
    .Code_Valid (Code_Valid),
    .Code_Err   (Code_Err),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0] dots;
    logic [3:0] code;
    logic       err;
  } vec_t;

  vec_t vecs[18];
  int   tests  = 0;
  int   failed = 0;
  int   ecount;
  int   vcnt;
  int   vfirst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_sub(input logic v, input int n);
    Submit_Btn = v;
    for (int i = 0; i < n; i++) begin
      step();
      ecount++;
      if (Code_Valid) begin
        vcnt++;
        if (vfirst < 0) vfirst = ecount;
      end
    end
  endtask

  task automatic clear_counts();
    ecount = 0;
    vcnt   = 0;
    vfirst = -1;
  endtask

  // Press with dots preset and synchronized, then release and wait for idle.
  task automatic do_press(input logic [5:0] d, input int hold);
    Dots_In    = d;
    Submit_Btn = 1'b0;
    repeat (3) step();
    clear_counts();
    run_sub(1'b1, hold);
    Submit_Btn = 1'b0;
    for (int e = 0; e < 40; e++) begin
      step();
      ecount++;
      if (Code_Valid) vcnt++;
      if (e >= 5 && !Busy) break;
    end
  endtask

  initial begin
    vecs[0]  = '{6'b000001, 4'b0000, 1'b0};
    vecs[1]  = '{6'b000011, 4'b0001, 1'b0};
    vecs[2]  = '{6'b001001, 4'b0010, 1'b0};
    vecs[3]  = '{6'b011001, 4'b0011, 1'b0};
    vecs[4]  = '{6'b010001, 4'b0100, 1'b0};
    vecs[5]  = '{6'b001011, 4'b0101, 1'b0};
    vecs[6]  = '{6'b011011, 4'b0110, 1'b0};
    vecs[7]  = '{6'b010011, 4'b0111, 1'b0};
    vecs[8]  = '{6'b001010, 4'b1000, 1'b0};
    vecs[9]  = '{6'b011010, 4'b1001, 1'b0};
    vecs[10] = '{6'b000111, 4'b1010, 1'b0};
    vecs[11] = '{6'b010101, 4'b1011, 1'b0};
    vecs[12] = '{6'b001111, 4'b1100, 1'b0};
    vecs[13] = '{6'b001110, 4'b1101, 1'b0};
    vecs[14] = '{6'b000000, 4'b1111, 1'b1};
    vecs[15] = '{6'b000010, 4'b1111, 1'b1};
    vecs[16] = '{6'b111111, 4'b1111, 1'b1};
    vecs[17] = '{6'b100101, 4'b1110, 1'b0};

    Rst        = 1'b0;
    Dots_In    = 6'b000000;
    Submit_Btn = 1'b0;
    Enable     = 1'b1;
    clear_counts();

    // Asynchronous reset, checked before any clock edge
    #2 Rst = 1'b1;
    #1;
    check("rst_code",  32'(Code_Out),   32'hF);
    check("rst_valid", 32'(Code_Valid), 32'h0);
    check("rst_err",   32'(Code_Err),   32'h0);
    check("rst_busy",  32'(Busy),       32'h0);
    step();
    step();
    Rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_press(vecs[i].dots, 20);
      check($sformatf("v%0d_first_edge", i), 32'(vfirst), 32'd7);
      check($sformatf("v%0d_nvalid", i),     32'(vcnt),   32'd1);
      check($sformatf("v%0d_code", i),       32'(Code_Out), 32'(vecs[i].code));
      check($sformatf("v%0d_err", i),        32'(Code_Err), 32'(vecs[i].err));
      check($sformatf("v%0d_busy_end", i),   32'(Busy),     32'h0);
    end

    // Short glitch: two cycles high is rejected, previous code held
    do_press(6'b001011, 2);
    check("glitch_nvalid", 32'(vcnt),     32'd0);
    check("glitch_busy",   32'(Busy),     32'h0);
    check("glitch_code",   32'(Code_Out), 32'hE);
    check("glitch_err",    32'(Code_Err), 32'h0);

    // Bounce 1,0,1,0 then held: one valid, debounce restarts at edge 7
    Dots_In = 6'b000011;
    repeat (3) step();
    clear_counts();
    run_sub(1'b1, 1);
    run_sub(1'b0, 1);
    run_sub(1'b1, 1);
    run_sub(1'b0, 1);
    run_sub(1'b1, 20);
    check("bounce_nvalid", 32'(vcnt),     32'd1);
    check("bounce_first",  32'(vfirst),   32'd11);
    check("bounce_code",   32'(Code_Out), 32'h1);
    run_sub(1'b0, 2);
    run_sub(1'b1, 10);
    check("short_release_nvalid", 32'(vcnt), 32'd1);
    check("short_release_busy",   32'(Busy), 32'h1);
    Dots_In = 6'b001001;
    run_sub(1'b0, 6);
    run_sub(1'b1, 10);
    check("second_press_nvalid", 32'(vcnt),     32'd2);
    check("second_press_code",   32'(Code_Out), 32'h2);
    run_sub(1'b0, 8);
    check("second_press_idle", 32'(Busy), 32'h0);

    // Enable dropped during DEBOUNCE
    Dots_In = 6'b011001;
    repeat (3) step();
    clear_counts();
    run_sub(1'b1, 4);
    check("en_busy_before", 32'(Busy), 32'h1);
    Enable = 1'b0;
    run_sub(1'b1, 1);
    check("en_busy_after", 32'(Busy), 32'h0);
    run_sub(1'b1, 10);
    check("en_nvalid", 32'(vcnt),     32'd0);
    check("en_busy",   32'(Busy),     32'h0);
    check("en_code",   32'(Code_Out), 32'h2);
    run_sub(1'b0, 4);
    Enable = 1'b1;

    // Reset pulsed while in RELEASE
    do_press(6'b000001, 20);
    Dots_In = 6'b010001;
    repeat (3) step();
    clear_counts();
    run_sub(1'b1, 12);
    check("rel_nvalid", 32'(vcnt),     32'd1);
    check("rel_code",   32'(Code_Out), 32'h4);
    check("rel_busy",   32'(Busy),     32'h1);
    #2 Rst = 1'b1;
    Submit_Btn = 1'b0;
    #1;
    check("rel_rst_code",  32'(Code_Out),   32'hF);
    check("rel_rst_valid", 32'(Code_Valid), 32'h0);
    check("rel_rst_err",   32'(Code_Err),   32'h0);
    check("rel_rst_busy",  32'(Busy),       32'h0);
    Rst = 1'b0;
    clear_counts();
    run_sub(1'b0, 10);
    check("rel_post_nvalid", 32'(vcnt),     32'd0);
    check("rel_post_busy",   32'(Busy),     32'h0);
    check("rel_post_code",   32'(Code_Out), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
